// File: rtl/ace_pkg.sv
`default_nettype none
// ============================================================================
// Module : ace_pkg
// ACE snoop channel types, CRRESP bit positions and snoop initiator states.
// Rev    : 1.0
// ============================================================================
package ace_pkg;

  localparam int c_cr_data_transfer = 0;
  localparam int c_cr_error         = 1;
  localparam int c_cr_pass_dirty    = 2;
  localparam int c_cr_is_shared     = 3;
  localparam int c_cr_was_unique    = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  snoop;
    logic [2:0]  prot;
  } ac_chan_t;

  typedef logic [4:0] cr_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic     ac_ready;
    logic     cr_valid;
    cr_chan_t cr_resp;
    logic     cd_valid;
    cd_chan_t cd;
  } snoop_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_CR = 3'd2,
    ST_DATA    = 3'd3,
    ST_RESULT  = 3'd4
  } state_e;

  function automatic logic cr_has_data(input cr_chan_t resp);
    return resp[c_cr_data_transfer];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ace_ccu_snoop_initiator_if.sv
`default_nettype none
// ============================================================================
// Module : ace_ccu_snoop_initiator_if
// Command, target-select, snoop bus, result and CD-forwarding signals.
// Rev    : 1.0
// ============================================================================
interface ace_ccu_snoop_initiator_if #(
  parameter int NumOup = 4
);
  import ace_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  ac_chan_t          cmd_ac;
  logic [NumOup-1:0] cmd_mask;
  logic [NumOup-1:0] sel;
  logic              sel_valid;
  logic              sel_ready;
  snoop_req_t        snoop_req;
  snoop_resp_t       snoop_resp;
  logic              result_valid;
  logic              result_ready;
  logic [4:0]        result;
  logic              data_valid;
  logic              data_ready;
  cd_chan_t          data;

  modport master (
    input  cmd_valid, cmd_ac, cmd_mask, sel_ready, snoop_resp, result_ready, data_ready,
    output cmd_ready, sel, sel_valid, snoop_req, result_valid, result, data_valid, data
  );

  modport slave (
    output cmd_valid, cmd_ac, cmd_mask, sel_ready, snoop_resp, result_ready, data_ready,
    input  cmd_ready, sel, sel_valid, snoop_req, result_valid, result, data_valid, data
  );

endinterface
`default_nettype wire

// File: rtl/ace_ccu_cd_beat_checker.sv
`default_nettype none
// ============================================================================
// Module : ace_ccu_cd_beat_checker
// Counts CD beats of one snoop and flags a last beat at the wrong position.
// Rev    : 1.0
// ============================================================================
module ace_ccu_cd_beat_checker #(
  parameter int CdBeats = 4,
  localparam int CntW   = $clog2(CdBeats + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic beat_i,
  input  logic last_i,
  output logic mismatch_o
);

  localparam logic [CntW-1:0] c_max      = CntW'(CdBeats);
  localparam logic [CntW-1:0] c_last_idx = CntW'(CdBeats - 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (beat_i && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // r_cnt holds the beats already taken, so the current beat is r_cnt+1;
  // a saturated counter never matches, which also flags over-long bursts.
  assign mismatch_o = last_i && (r_cnt != c_last_idx);

endmodule
`default_nettype wire

// File: rtl/ace_ccu_snoop_initiator.sv
`default_nettype none
// ============================================================================
// Module : ace_ccu_snoop_initiator
// Turns one snoop command into an AC request plus target mask, then collects CR/CD.
// Rev    : 1.0
// ============================================================================
module ace_ccu_snoop_initiator
  import ace_pkg::*;
#(
  parameter int NumOup  = 4,
  parameter int InpIdx  = 0,
  parameter int CdBeats = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  ace_ccu_snoop_initiator_if.master  bus
);

  localparam logic [NumOup-1:0] c_self_bit = NumOup'(1) << InpIdx;

  state_e            r_state, w_state_nxt;
  logic [NumOup-1:0] r_mask, w_mask_nxt;
  logic [NumOup-1:0] w_cmd_mask;
  ac_chan_t          r_ac, w_ac_nxt;
  cr_chan_t          r_result, w_result_nxt;
  logic              r_ac_done, w_ac_done_nxt;
  logic              r_sel_done, w_sel_done_nxt;

  logic              w_cmd_ready;
  logic              w_ac_valid;
  logic              w_sel_valid;
  logic              w_cr_ready;
  logic              w_cd_ready;
  logic              w_result_valid;
  logic              w_data_valid;
  cd_chan_t          w_data;
  logic              w_beat_clear;
  logic              w_beat;
  logic              w_len_err;

  assign w_cmd_mask = bus.cmd_mask & ~c_self_bit;
  assign w_beat     = (r_state == ST_DATA) && bus.snoop_resp.cd_valid && bus.data_ready;

  ace_ccu_cd_beat_checker #(
    .CdBeats (CdBeats)
  ) u_beat_checker (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (w_beat_clear),
    .beat_i     (w_beat),
    .last_i     (bus.snoop_resp.cd.last),
    .mismatch_o (w_len_err)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_mask     <= '0;
      r_ac       <= '0;
      r_result   <= '0;
      r_ac_done  <= 1'b0;
      r_sel_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mask     <= w_mask_nxt;
      r_ac       <= w_ac_nxt;
      r_result   <= w_result_nxt;
      r_ac_done  <= w_ac_done_nxt;
      r_sel_done <= w_sel_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_mask_nxt     = r_mask;
    w_ac_nxt       = r_ac;
    w_result_nxt   = r_result;
    w_ac_done_nxt  = r_ac_done;
    w_sel_done_nxt = r_sel_done;
    w_cmd_ready    = 1'b0;
    w_ac_valid     = 1'b0;
    w_sel_valid    = 1'b0;
    w_cr_ready     = 1'b0;
    w_cd_ready     = 1'b0;
    w_result_valid = 1'b0;
    w_data_valid   = 1'b0;
    w_data         = '0;
    w_beat_clear   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Ready is held low while reset is applied so every output reads 0.
        w_cmd_ready = rst_ni;
        if (bus.cmd_valid && rst_ni) begin
          w_mask_nxt   = w_cmd_mask;
          w_ac_nxt     = bus.cmd_ac;
          w_result_nxt = '0;
          w_state_nxt  = (w_cmd_mask == '0) ? ST_RESULT : ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        w_ac_valid     = !r_ac_done;
        w_sel_valid    = !r_sel_done;
        w_ac_done_nxt  = r_ac_done  | bus.snoop_resp.ac_ready;
        w_sel_done_nxt = r_sel_done | bus.sel_ready;
        if (w_ac_done_nxt && w_sel_done_nxt) begin
          w_ac_done_nxt  = 1'b0;
          w_sel_done_nxt = 1'b0;
          w_state_nxt    = ST_WAIT_CR;
        end
      end

      ST_WAIT_CR: begin
        // CD is buffered apart from CR in the interconnect, so holding it off is safe.
        w_cr_ready = 1'b1;
        if (bus.snoop_resp.cr_valid) begin
          w_result_nxt = bus.snoop_resp.cr_resp;
          if (cr_has_data(bus.snoop_resp.cr_resp)) begin
            w_beat_clear = 1'b1;
            w_state_nxt  = ST_DATA;
          end else begin
            w_state_nxt  = ST_RESULT;
          end
        end
      end

      ST_DATA: begin
        w_data_valid = bus.snoop_resp.cd_valid;
        w_cd_ready   = bus.data_ready;
        w_data       = bus.snoop_resp.cd;
        if (w_beat && bus.snoop_resp.cd.last) begin
          w_result_nxt[c_cr_error] = r_result[c_cr_error] | w_len_err;
          w_state_nxt              = ST_RESULT;
        end
      end

      ST_RESULT: begin
        w_result_valid = 1'b1;
        if (bus.result_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready    = w_cmd_ready;
  assign bus.sel          = r_mask;
  assign bus.sel_valid    = w_sel_valid;
  assign bus.snoop_req    = '{ac_valid: w_ac_valid, ac: r_ac, cr_ready: w_cr_ready, cd_ready: w_cd_ready};
  assign bus.result_valid = w_result_valid;
  assign bus.result       = r_result;
  assign bus.data_valid   = w_data_valid;
  assign bus.data         = w_data;

endmodule
`default_nettype wire
